// File: rtl/wave_gen_pkg.sv
// Shared types and default parameter values for the waveform generator.
package wave_gen_pkg;

    typedef enum logic [1:0] {
        MODE_SQUARE = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SINE   = 2'd3
    } mode_e;

    localparam int DATA_W_DEF  = 8;
    localparam int PHASE_W_DEF = 16;
    localparam int DIV_W_DEF   = 8;
    localparam int SHIFT_DEF   = 3;
    localparam int AMP_DEF     = 120;

endpackage

// File: rtl/wave_gen_if.sv
// Frequency-word valid/ready handshake between a controller and wave_gen.
interface wave_gen_if
    import wave_gen_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF
) ();

    logic [PHASE_W-1:0] freq_word;
    logic               freq_valid;
    logic               freq_ready;

    modport master (output freq_word, output freq_valid, input  freq_ready);
    modport slave  (input  freq_word, input  freq_valid, output freq_ready);

endinterface

// File: rtl/wave_gen_osc.sv
// Coupled-form sine/cos oscillator; advances one step per step pulse.
module wave_gen_osc
    import wave_gen_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SHIFT  = SHIFT_DEF,
    parameter int AMP    = AMP_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     step,
    input  logic                     clear,
    output logic signed [DATA_W-1:0] sine,
    output logic signed [DATA_W-1:0] cos
);

    localparam logic signed [DATA_W-1:0] AMP_V = DATA_W'(AMP);

    logic signed [DATA_W-1:0] sine_nxt;
    logic signed [DATA_W-1:0] cos_nxt;

    // cos uses the freshly updated sine, which keeps the orbit from spiralling out
    always_comb begin
        sine_nxt = sine + (cos >>> SHIFT);
        cos_nxt  = cos - (sine_nxt >>> SHIFT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sine <= '0;
            cos  <= AMP_V;
        end else if (clear) begin
            sine <= '0;
            cos  <= AMP_V;
        end else if (step) begin
            sine <= sine_nxt;
            cos  <= cos_nxt;
        end
    end

endmodule

// File: rtl/wave_gen.sv
// Waveform generator: phase accumulator with double-buffered frequency word,
// square/saw/triangle/sine output and clock divider. Triangle needs WAVE_GEN_TRIANGLE_EN.
module wave_gen
    import wave_gen_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int DIV_W   = DIV_W_DEF,
    parameter int SHIFT   = SHIFT_DEF,
    parameter int AMP     = AMP_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sync_clr,
    input  logic [1:0]        mode,
    wave_gen_if.slave         freq_if,
    input  logic [DIV_W-1:0]  div_ratio,
    output logic              clk_div,
    output logic [DATA_W-1:0] wave,
    output logic [DATA_W-1:0] sine,
    output logic [DATA_W-1:0] cos,
    output logic              wrap
);

    logic [PHASE_W-1:0]       phase;
    logic [PHASE_W-1:0]       active_word;
    logic [PHASE_W-1:0]       pend_word;
    logic                     pending;
    logic [PHASE_W:0]         sum;
    logic                     carry;
    logic                     accept;
    logic                     activate;
    logic [DATA_W-1:0]        wave_nxt;
    logic [DIV_W-1:0]         div_cnt;
    logic signed [DATA_W-1:0] osc_sine;
    logic signed [DATA_W-1:0] osc_cos;

    assign sum                = {1'b0, phase} + {1'b0, active_word};
    assign carry              = enable && !sync_clr && sum[PHASE_W];
    assign accept             = freq_if.freq_valid && !pending;
    // A stalled or zero-rate accumulator would never carry, so swap immediately
    assign activate           = pending && !sync_clr && (carry || !enable || active_word == '0);
    assign freq_if.freq_ready = !pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= '0;
            wrap  <= 1'b0;
        end else if (sync_clr) begin
            phase <= '0;
            wrap  <= 1'b0;
        end else if (enable) begin
            phase <= sum[PHASE_W-1:0];
            wrap  <= sum[PHASE_W];
        end else begin
            wrap  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_word <= '0;
            pend_word   <= '0;
            pending     <= 1'b0;
        end else if (activate) begin
            active_word <= pend_word;
            pending     <= 1'b0;
        end else if (accept) begin
            pend_word   <= freq_if.freq_word;
            pending     <= 1'b1;
        end
    end

    always_comb begin
        wave_nxt = phase[PHASE_W-1 -: DATA_W];
        case (mode_e'(mode))
            MODE_SQUARE: wave_nxt = phase[PHASE_W-1] ? '0 : '1;
            MODE_SAW:    wave_nxt = phase[PHASE_W-1 -: DATA_W];
`ifdef WAVE_GEN_TRIANGLE_EN
            MODE_TRI:    wave_nxt = phase[PHASE_W-2 -: DATA_W] ^ {DATA_W{phase[PHASE_W-1]}};
`else
            MODE_TRI:    wave_nxt = phase[PHASE_W-1 -: DATA_W];
`endif
            MODE_SINE:   wave_nxt = osc_sine;
            default:     wave_nxt = phase[PHASE_W-1 -: DATA_W];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wave <= '0;
        else       wave <= wave_nxt;
    end

    wave_gen_osc #(
        .DATA_W (DATA_W),
        .SHIFT  (SHIFT),
        .AMP    (AMP)
    ) u_osc (
        .clk    (clk),
        .reset  (reset),
        .step   (wrap),
        .clear  (sync_clr),
        .sine   (osc_sine),
        .cos    (osc_cos)
    );

    assign sine = osc_sine;
    assign cos  = osc_cos;

    // Down-counter starts at 0 so the first edge after reset toggles clk_div
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            clk_div <= 1'b0;
        end else if (div_cnt == '0) begin
            div_cnt <= div_ratio;
            clk_div <= ~clk_div;
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_wave_gen.sv
// Directed bench for wave_gen: reset, divider, saw sequence, handshake, square,
// mode 2, oscillator steps, sync_clr and mid-run reset.
module tb_wave_gen;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       sync_clr;
    logic [1:0] mode;
    logic [7:0] div_ratio;
    logic       clk_div;
    logic [7:0] wave;
    logic [7:0] sine;
    logic [7:0] cos;
    logic       wrap;

    int n_pass  = 0;
    int n_total = 0;

    wave_gen_if #(.PHASE_W(16)) freq_if ();

    wave_gen dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .sync_clr  (sync_clr),
        .mode      (mode),
        .freq_if   (freq_if),
        .div_ratio (div_ratio),
        .clk_div   (clk_div),
        .wave      (wave),
        .sine      (sine),
        .cos       (cos),
        .wrap      (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        sync_clr  = 1'b0;
        mode      = 2'd1;
        div_ratio = 8'd2;
        freq_if.freq_word  = 16'h0000;
        freq_if.freq_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_wave", wave, 8'h00);
        check("rst_sine", sine, 8'd0);
        check("rst_cos", cos, 8'd120);
        check("rst_clk_div", clk_div, 1'b0);
        check("rst_ready", freq_if.freq_ready, 1'b1);
        check("rst_wrap", wrap, 1'b0);

        // div_ratio=2: high for 3 edges, low for 3 edges
        for (int i = 0; i < 6; i++) begin
            tick();
            check("clk_div_r2", clk_div, (i < 3) ? 1'b1 : 1'b0);
        end
        div_ratio = 8'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("clk_div_r0", clk_div, (i % 2 == 0) ? 1'b1 : 1'b0);
        end

        // load 0x1000 while idle: activates the cycle after acceptance
        freq_if.freq_valid = 1'b1;
        freq_if.freq_word  = 16'h1000;
        tick();
        freq_if.freq_valid = 1'b0;
        check("load_ready_low", freq_if.freq_ready, 1'b0);
        tick();
        check("load_ready_high", freq_if.freq_ready, 1'b1);
        enable = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            tick();
            check("saw_wave", wave, ((k - 1) * 16) & 255);
            check("saw_wrap", wrap, (k % 16 == 0) ? 1'b1 : 1'b0);
        end

        // phase now 0x2000; pending 0x2000 waits for the carry 14 edges later
        freq_if.freq_valid = 1'b1;
        freq_if.freq_word  = 16'h2000;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 1) freq_if.freq_word = 16'h4000;
            check("hs_ready", freq_if.freq_ready, (i == 14) ? 1'b1 : 1'b0);
            check("hs_wrap", wrap, (i == 14) ? 1'b1 : 1'b0);
        end
        tick();
        check("hs_second_accept", freq_if.freq_ready, 1'b0);
        freq_if.freq_valid = 1'b0;
        tick();
        check("hs_new_rate", wave, 8'h20);
        repeat (6) tick();
        check("hs_wrap2", wrap, 1'b1);
        check("hs_ready2", freq_if.freq_ready, 1'b1);
        repeat (2) tick();
        check("hs_rate_4000", wave, 8'h40);

        // square: phase 0x8000, 0xC000, 0x0000
        mode = 2'd0;
        tick();
        check("sq_hi_phase", wave, 8'h00);
        tick();
        check("sq_hi_phase2", wave, 8'h00);
        tick();
        check("sq_lo_phase", wave, 8'hFF);

        // mode 2 on phase 0x4000 then 0x8000
        mode = 2'd2;
        tick();
`ifdef WAVE_GEN_TRIANGLE_EN
        check("mode2_a", wave, 8'h80);
`else
        check("mode2_a", wave, 8'h40);
`endif
        tick();
`ifdef WAVE_GEN_TRIANGLE_EN
        check("mode2_b", wave, 8'hFF);
`else
        check("mode2_b", wave, 8'h80);
`endif

        // oscillator: clear, load 0x8000, wrap every 2 cycles
        mode     = 2'd3;
        sync_clr = 1'b1;
        enable   = 1'b0;
        freq_if.freq_valid = 1'b1;
        freq_if.freq_word  = 16'h8000;
        tick();
        check("clr_sine", sine, 8'd0);
        check("clr_cos", cos, 8'd120);
        check("clr_keeps_pending", freq_if.freq_ready, 1'b0);
        sync_clr = 1'b0;
        freq_if.freq_valid = 1'b0;
        tick();
        check("osc_load_ready", freq_if.freq_ready, 1'b1);
        enable = 1'b1;
        tick();
        tick();
        check("osc_wrap1", wrap, 1'b1);
        tick();
        check("osc_sine1", sine, 8'd15);
        check("osc_cos1", cos, 8'd119);
        check("osc_wrap_pulse", wrap, 1'b0);
        tick();
        check("sine_wave", wave, 8'd15);
        tick();
        check("osc_sine2", sine, 8'd29);
        check("osc_cos2", cos, 8'd116);

        // sync_clr on a carrying cycle suppresses wrap
        sync_clr = 1'b1;
        tick();
        check("clr2_sine", sine, 8'd0);
        check("clr2_cos", cos, 8'd120);
        check("clr2_no_wrap", wrap, 1'b0);
        sync_clr = 1'b0;
        tick();
        check("clr2_wave", wave, 8'd0);
        tick();
        check("clr2_wrap_after", wrap, 1'b1);

        // reset mid-operation discards a pending word
        freq_if.freq_valid = 1'b1;
        freq_if.freq_word  = 16'h1234;
        tick();
        check("mid_pending", freq_if.freq_ready, 1'b0);
        freq_if.freq_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_ready", freq_if.freq_ready, 1'b1);
        check("mid_rst_clk_div", clk_div, 1'b0);
        check("mid_rst_wave", wave, 8'h00);
        check("mid_rst_cos", cos, 8'd120);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("post_rst_clk_div", clk_div, 1'b1);
        check("post_rst_ready", freq_if.freq_ready, 1'b1);
        check("post_rst_wave", wave, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wave_gen.md
WAVE_GEN -- requirements
Module: wave_gen

Interface
REQ-001 Parameter DATA_W, default 8, output sample width in bits.
REQ-002 Parameter PHASE_W, default 16, phase accumulator width in bits; PHASE_W >= DATA_W+1.
REQ-003 Parameter DIV_W, default 8, divider ratio width in bits.
REQ-004 Parameter SHIFT, default 3, sine/cos oscillator coupling shift.
REQ-005 Parameter AMP, default 120, oscillator initial cos value.
REQ-006 Port clk, input, 1 bit, single clock; all logic SHALL be clocked on its rising edge.
REQ-007 Port reset, input, 1 bit, asynchronous active-high reset.
REQ-008 Port enable, input, 1 bit, advances the phase accumulator.
REQ-009 Port sync_clr, input, 1 bit, synchronous clear of phase and oscillator.
REQ-010 Port mode, input, 2 bits: 0 square, 1 saw, 2 triangle, 3 sine.
REQ-011 Port freq_word, input, PHASE_W bits, phase increment.
REQ-012 Port freq_valid, input, 1 bit; port freq_ready, output, 1 bit; freq_word handshake.
REQ-013 Port div_ratio, input, DIV_W bits, clock divider half-period minus one.
REQ-014 Port clk_div, output, 1 bit, divided clock.
REQ-015 Port wave, output, DATA_W bits, selected waveform, registered.
REQ-016 Port sine and cos, outputs, DATA_W bits each, two's-complement oscillator state.
REQ-017 Port wrap, output, 1 bit, one-cycle pulse on accumulator overflow.

Function
REQ-018 Phase SHALL add the active freq word modulo 2^PHASE_W on every cycle with enable=1; hold otherwise.
REQ-019 wrap SHALL be 1 in the cycle after an addition carries out of PHASE_W bits.
REQ-020 freq_ready SHALL be 1 whenever no word is pending; a word is accepted on freq_valid&&freq_ready.
REQ-021 A pending word SHALL become active in the cycle its accumulator carry occurs, or on the next cycle if enable=0 or active word is 0; freq_ready returns to 1 the cycle after.
REQ-022 A word accepted in the same cycle as a carry SHALL wait for the following carry.
REQ-023 wave SHALL be computed from the registered phase with 1 cycle latency: square all-ones when phase MSB=0 else 0; saw = top DATA_W phase bits; triangle = phase bits [PHASE_W-2 -: DATA_W], inverted when MSB=1; sine mode = sine output.
REQ-024 Square/saw/triangle SHALL be unsigned offset-binary; sine/cos SHALL be two's complement.
REQ-025 Oscillator SHALL step once per wrap pulse, regardless of mode: sine <= sine + (cos >>> SHIFT); cos <= cos - (new sine >>> SHIFT), arithmetic shifts, DATA_W wrap-around.
REQ-026 Mode changes SHALL take effect at the next wave update without disturbing phase or oscillator.
REQ-027 sync_clr SHALL set phase=0, sine=0, cos=AMP, suppress wrap that cycle, preserve any pending word; priority over enable.
REQ-028 Divider counter SHALL count down to 0, then toggle clk_div and reload from current div_ratio; runs independent of enable; div_ratio=0 toggles every cycle.

Reset
REQ-029 On reset: phase=0, active and pending freq word=0, freq_ready=1, wrap=0, wave=0, sine=0, cos=AMP, divider counter=0, clk_div=0.
REQ-030 Reset mid-operation SHALL discard pending words; first clk_div toggle on first clock after release.

Configuration
REQ-031 Macro WAVE_GEN_TRIANGLE_EN defined: mode 2 produces triangle per REQ-023.
REQ-032 Macro WAVE_GEN_TRIANGLE_EN undefined: triangle logic absent; mode 2 SHALL behave exactly as mode 1.

Structure
REQ-033 Package wave_gen_pkg SHALL hold the mode enum and default parameter constants.
REQ-034 Sub-module wave_gen_osc SHALL contain the sine/cos oscillator (step, clear inputs).

Verification
REQ-035 Reset release, mode=1 -> wave=0, sine=0, cos=120, clk_div=0, freq_ready=1, wrap=0.
REQ-036 mode=1, freq_word=0x1000 loaded, enable=1 -> wave 0x00,0x10..0xF0 repeating, wrap every 16 cycles.
REQ-037 freq_valid held while word pending -> freq_ready=0 until carry, new word accepted cycle after freq_ready rises.
REQ-038 div_ratio=2 -> clk_div period 6 cycles; div_ratio=0 -> period 2 cycles.
REQ-039 mode=3, freq_word=0x8000 -> after first wrap sine=15, cos=119; sync_clr -> sine=0, cos=120.
REQ-040 WAVE_GEN_TRIANGLE_EN undefined, mode=2 -> wave identical to mode=1 every cycle.
